// File: rtl/seqsub_pkg.sv
// rtl/seqsub_pkg.sv - shared definitions for the digit-serial subtractor
// Contents: FSM state encoding, default operand/digit widths, NDIG helper.
package seqsub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit passes needed for one operand.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_subtract.sv
// rtl/digit_subtract.sv - combinational DIGIT-wide subtract with borrow
// Ports:
//   x, y : DIGIT-bit minuend / subtrahend digits
//   bi   : borrow in
//   d    : x - y - bi modulo 2^DIGIT
//   bo   : borrow out (1 when x < y + bi)
module digit_subtract #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  // One guard bit on top: it ends up set exactly when the subtraction wraps.
  logic [DIGIT:0] r;

  assign r  = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d  = r[DIGIT-1:0];
  assign bo = r[DIGIT];

endmodule

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - digit-serial a - b - bin with valid/ready handshakes
// Ports:
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (diff, bout, ovf)
//   diff                 : a - b - bin modulo 2^WIDTH
//   bout                 : unsigned borrow out
//   ovf                  : signed overflow flag, built only with SEQSUB_OVF_EN
//                          defined; tied to 0 otherwise
module seq_subtractor
  import seqsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("seq_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res_sh;
  logic                   borrow;
  logic [DIGIT-1:0]       dig_d;
  logic                   dig_bo;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   accept;
  logic                   run_last;

  assign accept   = (state == IDLE) && in_valid;
  // RUN spends NDIG cycles on digits plus one final cycle (cnt == NDIG)
  // that publishes the result registers on the way into DONE.
  assign run_last = (state == RUN) && (cnt == LAST);
  // New digit enters from the MSB side; the slice also covers DIGIT == WIDTH.
  assign res_cat  = {dig_d, res_sh};

  digit_subtract #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (borrow),
    .d  (dig_d),
    .bo (dig_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (run_last) begin
      diff <= res_sh;
      bout <= borrow;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_cat[WIDTH+DIGIT-1:DIGIT];
      borrow <= dig_bo;
      cnt    <= cnt + 1'b1;
    end
  end

`ifdef SEQSUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep them aside.
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (run_last) begin
      ovf <= (a_msb != b_msb) && (res_sh[WIDTH-1] != a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - randomized and directed bench for seq_subtractor
module tb_seq_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [15:0] a1 = '0;
  logic [15:0] b1 = '0;
  logic        bin1 = 1'b0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [15:0] diff1;
  logic        bout1;
  logic        ovf1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(16)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .diff      (diff1),
    .bout      (bout1),
    .ovf       (ovf1)
  );

  // Reference: integer arithmetic on the whole operands.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    res_t r;
    int   v;
    v      = int'(x) - int'(y) - int'(bi);
    r.bout = (v < 0);
    r.diff = v[15:0];
`ifdef SEQSUB_OVF_EN
    r.ovf  = (x[15] != y[15]) && (r.diff[15] != x[15]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic op(input logic [15:0] xa, input logic [15:0] xb, input logic xbin, input int hold);
    res_t e;
    int   n;
    int   lat;
    e = model(xa, xb, xbin);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("diff", 32'(diff), 32'(e.diff));
    chk("bout", 32'(bout), 32'(e.bout));
    chk("ovf", 32'(ovf), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_diff", 32'(diff), 32'(e.diff));
      chk("hold_bout", 32'(bout), 32'(e.bout));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_diff_held", 32'(diff), 32'(e.diff));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   lat;
    logic [15:0] ra, rb;
    logic        rbin;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst1_in_ready", 32'(in_ready1), 32'd1);

    // out_ready with nothing pending must do nothing
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_out_ready_valid", 32'(out_valid), 32'd0);
    chk("idle_out_ready_rdy", 32'(in_ready), 32'd1);

    op(16'h1234, 16'h0234, 1'b0, 0);
    op(16'h0000, 16'h0001, 1'b0, 0);
    op(16'h0005, 16'h0003, 1'b1, 0);
    op(16'h8000, 16'h0001, 1'b0, 0);
    op(16'h7FFF, 16'hFFFF, 1'b1, 7);
    op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    op(16'h0000, 16'h0000, 1'b0, 0);

    // reset during the second RUN cycle
    a = 16'hBEEF; b = 16'h1234; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_diff", 32'(diff), 32'd0);
    chk("midrun_bout", 32'(bout), 32'd0);
    chk("midrun_ovf", 32'(ovf), 32'd0);
    repeat (8) @(posedge clk);
    #1 chk("midrun_no_result", 32'(out_valid), 32'd0);
    op(16'hA5A5, 16'h5A5A, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // single-pass instance
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        ra = 16'hAAAA; rb = 16'h5555; rbin = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      end
      e = model(ra, rb, rbin);
      a1 = ra; b1 = rb; bin1 = rbin; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("d16_latency", 32'(lat), 32'd2);
      chk("d16_diff", 32'(diff1), 32'(e.diff));
      chk("d16_bout", 32'(bout1), 32'(e.bout));
      chk("d16_ovf", 32'(ovf1), 32'(e.ovf));
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      chk("d16_in_ready", 32'(in_ready1), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
